// File: rtl/key_step_conditioner_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_step_conditioner_pkg : shared state encoding and helpers (rev 1.0)
// ----------------------------------------------------------------------------
package key_step_conditioner_pkg;

   localparam int unsigned c_state_w = 3;

   typedef enum logic [c_state_w-1:0] {
      KC_IDLE      = 3'd0,
      KC_PRESS_CHK = 3'd1,
      KC_HELD      = 3'd2,
      KC_REPEAT    = 3'd3,
      KC_REL_CHK   = 3'd4
   } kc_state_e;

   function automatic logic kc_is_held(input kc_state_e s);
      return (s == KC_HELD) || (s == KC_REPEAT) || (s == KC_REL_CHK);
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_step_conditioner_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_step_conditioner_if : raw key input and conditioned outputs (rev 1.0)
// ----------------------------------------------------------------------------
interface key_step_conditioner_if;
   logic key_n;
   logic step;
   logic held;
   logic repeating;

   modport master (output key_n, input step, input held, input repeating);
   modport slave  (input key_n, output step, output held, output repeating);
endinterface
`default_nettype wire

// File: rtl/key_step_conditioner_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_2ff : 1-bit two-flop synchronizer with configurable reset value (rev 1.0)
// ----------------------------------------------------------------------------
module sync_2ff #(
   parameter bit INIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = i_async;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= INIT;
         sync_q <= INIT;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/key_step_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_step_conditioner : debounced single-cycle step pulse with auto-repeat (rev 1.0)
// ----------------------------------------------------------------------------
module key_step_conditioner
   import key_step_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 10000000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic                   clk,
   input  logic                   reset,
   key_step_conditioner_if.slave  kif
);

   localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
   localparam bit               c_repeat_en = (HOLD_CYCLES != 0);

   logic             key_sync;
   logic             key_s;
   kc_state_e        state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             step_d, step_q;
   logic             held_d, held_q;
   logic             repeating_d, repeating_q;

   sync_2ff #(
      .INIT (1'b1)
   ) u_sync (
      .clk     (clk),
      .rst     (reset),
      .i_async (kif.key_n),
      .o_sync  (key_sync)
   );

   assign key_s = ~key_sync;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = 1'b0;

      case (state_q)
         KC_IDLE: begin
            if (key_s) begin
               state_d = KC_PRESS_CHK;
               cnt_d   = '0;
            end
         end
         KC_PRESS_CHK: begin
            if (!key_s) begin
               state_d = KC_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == c_deb_last) begin
               state_d = KC_HELD;
               cnt_d   = '0;
               step_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + c_one;
            end
         end
         KC_HELD: begin
            if (!key_s) begin
               state_d = KC_REL_CHK;
               cnt_d   = '0;
            end else if (c_repeat_en && (cnt_q == c_hold_last)) begin
               state_d = KC_REPEAT;
               cnt_d   = '0;
               step_d  = 1'b1;
            end else if (c_repeat_en) begin
               // With repeat disabled the hold timer is parked at zero so it cannot wrap.
               cnt_d = cnt_q + c_one;
            end
         end
         KC_REPEAT: begin
            if (!key_s) begin
               state_d = KC_REL_CHK;
               cnt_d   = '0;
            end else if (cnt_q == c_rep_last) begin
               cnt_d  = '0;
               step_d = 1'b1;
            end else begin
               cnt_d = cnt_q + c_one;
            end
         end
         KC_REL_CHK: begin
            if (key_s) begin
               state_d = KC_HELD;
               cnt_d   = '0;
            end else if (cnt_q == c_deb_last) begin
               state_d = KC_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_one;
            end
         end
         default: begin
            state_d = KC_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Level outputs follow the next state so they register together with it.
      held_d      = kc_is_held(state_d);
      repeating_d = (state_d == KC_REPEAT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= KC_IDLE;
         cnt_q       <= '0;
         step_q      <= 1'b0;
         held_q      <= 1'b0;
         repeating_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         held_q      <= held_d;
         repeating_q <= repeating_d;
      end
   end

   assign kif.step      = step_q;
   assign kif.held      = held_q;
   assign kif.repeating = repeating_q;

endmodule
`default_nettype wire

// File: tb/tb_key_step_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_key_step_conditioner : scoreboard bench for key_step_conditioner (rev 1.0)
// ----------------------------------------------------------------------------
module tb_key_step_conditioner;

   localparam int D = 4;
   localparam int H = 8;
   localparam int R = 3;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   qa[$];
   int   qb[$];
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;
   logic rep_b_seen = 1'b0;

   key_step_conditioner_if ifa ();
   key_step_conditioner_if ifb ();

   key_step_conditioner #(
      .DEBOUNCE_CYCLES (D), .HOLD_CYCLES (H), .REPEAT_CYCLES (R), .CNT_W (4)
   ) dut_a (
      .clk (clk), .reset (reset), .kif (ifa.slave)
   );

   key_step_conditioner #(
      .DEBOUNCE_CYCLES (D), .HOLD_CYCLES (0), .REPEAT_CYCLES (R), .CNT_W (4)
   ) dut_b (
      .clk (clk), .reset (reset), .kif (ifb.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s @cyc %0d", name, cyc);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Expected steps for a press driven at negedge c and released at negedge c+l.
   task automatic push_press_a(input int c, input int l);
      int t;
      qa.push_back(c + D + 3);
      t = c + D + 3 + H;
      while (t <= c + l + 2) begin
         qa.push_back(t);
         t = t + R;
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (ifa.step) begin
            if (prev_a) flag("step_a_back_to_back");
            if (qa.size() == 0) flag("step_a_unexpected");
            else check("step_a_cycle", cyc, qa.pop_front());
         end
         if (ifb.step) begin
            if (prev_b) flag("step_b_back_to_back");
            if (qb.size() == 0) flag("step_b_unexpected");
            else check("step_b_cycle", cyc, qb.pop_front());
         end
         if (ifb.repeating) rep_b_seen = 1'b1;
         prev_a = ifa.step;
         prev_b = ifb.step;
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset     = 1'b1;
      ifa.key_n = 1'b1;
      ifb.key_n = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_step_a", int'(ifa.step), 0);
      check("reset_held_a", int'(ifa.held), 0);
      check("reset_rep_a", int'(ifa.repeating), 0);
      check("reset_held_b", int'(ifb.held), 0);
      fork
         monitor();
      join_none
      wait_to(cyc + 5);

      // Clean press, released before the hold time expires
      c = cyc;
      ifa.key_n = 1'b0;
      push_press_a(c, 10);
      wait_to(c + 6);
      check("t1_held_before", int'(ifa.held), 0);
      wait_to(c + 7);
      check("t1_held_at_step", int'(ifa.held), 1);
      wait_to(c + 10);
      ifa.key_n = 1'b1;
      wait_to(c + 16);
      check("t1_held_rel_chk", int'(ifa.held), 1);
      wait_to(c + 17);
      check("t1_held_idle", int'(ifa.held), 0);
      wait_to(c + 22);

      // Bounce shorter than the debounce window
      c = cyc;
      ifa.key_n = 1'b0;
      wait_to(c + 3);
      ifa.key_n = 1'b1;
      wait_to(c + 5);
      ifa.key_n = 1'b0;
      wait_to(c + 6);
      check("t2_held_mid", int'(ifa.held), 0);
      wait_to(c + 8);
      ifa.key_n = 1'b1;
      wait_to(c + 14);
      check("t2_held_end", int'(ifa.held), 0);
      check("t2_rep_end", int'(ifa.repeating), 0);
      wait_to(c + 20);

      // Auto-repeat over a 40-cycle hold
      c = cyc;
      ifa.key_n = 1'b0;
      push_press_a(c, 40);
      wait_to(c + 14);
      check("t3_rep_before", int'(ifa.repeating), 0);
      wait_to(c + 15);
      check("t3_rep_second_step", int'(ifa.repeating), 1);
      wait_to(c + 40);
      ifa.key_n = 1'b1;
      wait_to(c + 42);
      check("t3_rep_last", int'(ifa.repeating), 1);
      wait_to(c + 43);
      check("t3_rep_released", int'(ifa.repeating), 0);
      check("t3_held_rel_chk", int'(ifa.held), 1);
      wait_to(c + 47);
      check("t3_held_idle", int'(ifa.held), 0);
      wait_to(c + 55);

      // Release bounce returns to HELD, then a real release
      c = cyc;
      ifa.key_n = 1'b0;
      push_press_a(c, 9);
      wait_to(c + 9);
      ifa.key_n = 1'b1;
      wait_to(c + 11);
      ifa.key_n = 1'b0;
      wait_to(c + 13);
      check("t4_held_in_rel_chk", int'(ifa.held), 1);
      wait_to(c + 16);
      ifa.key_n = 1'b1;
      wait_to(c + 22);
      check("t4_held_before_idle", int'(ifa.held), 1);
      wait_to(c + 23);
      check("t4_held_idle", int'(ifa.held), 0);
      wait_to(c + 30);

      // Reset during REPEAT with the key still down
      c = cyc;
      ifa.key_n = 1'b0;
      qa.push_back(c + D + 3);
      qa.push_back(c + D + 3 + H);
      wait_to(c + 17);
      reset = 1'b1;
      wait_to(c + 18);
      reset = 1'b0;
      check("t5_step_after_reset", int'(ifa.step), 0);
      check("t5_held_after_reset", int'(ifa.held), 0);
      check("t5_rep_after_reset", int'(ifa.repeating), 0);
      qa.push_back(c + 19 + D + 2);
      wait_to(c + 24);
      check("t5_held_pre_step", int'(ifa.held), 0);
      wait_to(c + 27);
      ifa.key_n = 1'b1;
      wait_to(c + 34);
      check("t5_held_idle", int'(ifa.held), 0);
      wait_to(c + 40);

      // Repeat disabled: long hold gives exactly one step
      c = cyc;
      ifb.key_n = 1'b0;
      qb.push_back(c + D + 3);
      wait_to(c + 10);
      check("t6_held_b", int'(ifb.held), 1);
      wait_to(c + 50);
      ifb.key_n = 1'b1;
      wait_to(c + 57);
      check("t6_held_b_idle", int'(ifb.held), 0);
      wait_to(c + 62);

      check("qa_left", qa.size(), 0);
      check("qb_left", qb.size(), 0);
      check("t6_rep_b_seen", int'(rep_b_seen), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
